// File: rtl/tug_referee_if.sv
// Signal bundle between the tug-of-war referee and its surroundings.
// The referee reads the key levels and the light chain state. It drives the
// move and recenter pulses back to the chain, and reports the score.
interface tug_referee_if #(
  parameter int NLIGHTS = 9
);
  // Key levels (already synchronized) and current chain state.
  logic               L;
  logic               R;
  logic [NLIGHTS-1:0] lights;

  // Pulses to the light chain.
  logic               Lpress;
  logic               Rpress;
  logic               win;

  // Match status.
  logic [2:0]         leftScore;
  logic [2:0]         rightScore;
  logic [1:0]         lastWinner;
  logic               gameOver;

  // Keys/lights source side (player panel plus light chain).
  modport master (
    output L,
    output R,
    output lights,
    input  Lpress,
    input  Rpress,
    input  win,
    input  leftScore,
    input  rightScore,
    input  lastWinner,
    input  gameOver
  );

  // Referee side.
  modport slave (
    input  L,
    input  R,
    input  lights,
    output Lpress,
    output Rpress,
    output win,
    output leftScore,
    output rightScore,
    output lastWinner,
    output gameOver
  );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war referee.
// It turns the key levels into single-cycle move pulses and detects a point
// when the puck sits on an end light and that side presses again. After a
// point it freezes play for HOLD_CYCLES cycles and pulses win on the last of
// them. The match ends once a player reaches SCORE_MAX.
// Lpress/Rpress are Mealy outputs, so the chain moves in the same cycle the
// key edge is seen. All other outputs are decoded from registers.
module tug_referee #(
  parameter int NLIGHTS     = 9,
  parameter int HOLD_CYCLES = 4,
  parameter int SCORE_MAX   = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  tug_referee_if.slave  bus
);

  localparam int              CNT_W        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]      SCORE_TARGET = 3'(SCORE_MAX);
  localparam logic [2:0]      SCORE_SAT    = 3'd7;
  localparam logic [1:0]      WIN_NONE     = 2'b00;
  localparam logic [1:0]      WIN_LEFT     = 2'b10;
  localparam logic [1:0]      WIN_RIGHT    = 2'b01;

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_HOLD = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Score increment that sticks at the 3-bit maximum. Whether the top value
  // is reachable depends only on SCORE_MAX.
  function automatic logic [2:0] sat_inc(input logic [2:0] score);
    logic [2:0] result;
    if (score == SCORE_SAT) begin
      result = score;
    end else begin
      result = score + 3'd1;
    end
    return result;
  endfunction

  // Registered state.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       left_score_q, left_score_d;
  logic [2:0]       right_score_q, right_score_d;
  logic [1:0]       last_winner_q, last_winner_d;
  logic             pending_done_q, pending_done_d;
  logic             l_prev_q, r_prev_q;

  // Decoded key events.
  logic             le_s, re_s;
  logic             l_move_s, r_move_s;
  logic             l_point_s, r_point_s;
  logic [2:0]       left_inc_s, right_inc_s;

  // Combinational outputs.
  logic             lpress_s, rpress_s, win_s;

  // Rising-edge detection. Simultaneous edges cancel each other (a tie).
  assign le_s       = bus.L & ~l_prev_q;
  assign re_s       = bus.R & ~r_prev_q;
  assign l_move_s   = le_s & ~re_s;
  assign r_move_s   = re_s & ~le_s;

  // A point needs the puck on the presser's own end light. Only the end bit
  // is examined; the chain is not checked for one-hot.
  assign l_point_s  = l_move_s & bus.lights[NLIGHTS-1];
  assign r_point_s  = r_move_s & bus.lights[0];

  assign left_inc_s  = sat_inc(left_score_q);
  assign right_inc_s = sat_inc(right_score_q);

  // Previous key levels, tracked in every state so that a key held across
  // HOLD or reset never produces a late press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      l_prev_q <= 1'b1;
      r_prev_q <= 1'b1;
    end else begin
      l_prev_q <= bus.L;
      r_prev_q <= bus.R;
    end
  end

  // FSM state, hold counter and score registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_PLAY;
      hold_cnt_q     <= CNT_ZERO;
      left_score_q   <= 3'd0;
      right_score_q  <= 3'd0;
      last_winner_q  <= WIN_NONE;
      pending_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      left_score_q   <= left_score_d;
      right_score_q  <= right_score_d;
      last_winner_q  <= last_winner_d;
      pending_done_q <= pending_done_d;
    end
  end

  // Next-state, scoring and pulse generation.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    left_score_d   = left_score_q;
    right_score_d  = right_score_q;
    last_winner_d  = last_winner_q;
    pending_done_d = pending_done_q;
    lpress_s       = 1'b0;
    rpress_s       = 1'b0;
    win_s          = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (l_point_s) begin
          // The winning press is swallowed; the chain is recentered by win.
          left_score_d   = left_inc_s;
          last_winner_d  = WIN_LEFT;
          hold_cnt_d     = HOLD_LOAD;
          pending_done_d = (left_inc_s == SCORE_TARGET);
          state_d        = ST_HOLD;
        end else if (r_point_s) begin
          right_score_d  = right_inc_s;
          last_winner_d  = WIN_RIGHT;
          hold_cnt_d     = HOLD_LOAD;
          pending_done_d = (right_inc_s == SCORE_TARGET);
          state_d        = ST_HOLD;
        end else begin
          lpress_s = l_move_s;
          rpress_s = r_move_s;
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == CNT_ZERO) begin
          // Last frozen cycle: recenter the chain, then resume or finish.
          win_s = 1'b1;
          if (pending_done_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        // Match over: everything frozen until Reset.
        state_d = ST_DONE;
      end

      default: begin
        // Unreachable encoding: fall back to a safe idle state.
        state_d = ST_PLAY;
      end
    endcase
  end

  assign bus.Lpress     = lpress_s;
  assign bus.Rpress     = rpress_s;
  assign bus.win        = win_s;
  assign bus.leftScore  = left_score_q;
  assign bus.rightScore = right_score_q;
  assign bus.lastWinner = last_winner_q;
  assign bus.gameOver   = (state_q == ST_DONE);

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee (NLIGHTS=9, HOLD_CYCLES=4, SCORE_MAX=7).
// Inputs change 1 ns after a rising edge, and outputs are sampled 1 ns after
// that. Expected values are worked out by hand from the game rules.
module tb_tug_referee;

  logic Clock;
  logic Reset;
  int   n_chk;
  int   n_pass;

  tug_referee_if #(.NLIGHTS(9)) bus ();

  tug_referee #(
    .NLIGHTS    (9),
    .HOLD_CYCLES(4),
    .SCORE_MAX  (7)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Check the four pulse/status bits at once.
  task automatic chk_pulses(input string tag, input logic lp, input logic rp,
                            input logic w, input logic go);
    chk({tag, ".Lpress"},   32'(bus.Lpress),   32'(lp));
    chk({tag, ".Rpress"},   32'(bus.Rpress),   32'(rp));
    chk({tag, ".win"},      32'(bus.win),      32'(w));
    chk({tag, ".gameOver"}, 32'(bus.gameOver), 32'(go));
  endtask

  // Check both scores and the last winner.
  task automatic chk_score(input string tag, input logic [2:0] ls,
                           input logic [2:0] rs, input logic [1:0] lw);
    chk({tag, ".leftScore"},  32'(bus.leftScore),  32'(ls));
    chk({tag, ".rightScore"}, 32'(bus.rightScore), 32'(rs));
    chk({tag, ".lastWinner"}, 32'(bus.lastWinner), 32'(lw));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // Reset with both keys held down.
    Reset      = 1'b1;
    bus.L      = 1'b1;
    bus.R      = 1'b1;
    bus.lights = 9'b000010000;
    #1;
    chk_pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_score("reset", 3'd0, 3'd0, 2'b00);
    tick();
    tick();
    chk_pulses("reset_clk", 1'b0, 1'b0, 1'b0, 1'b0);

    // Release reset with keys still held: no press may appear.
    Reset = 1'b0;
    #1;
    chk_pulses("held_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_pulses("held_rel2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Release both keys, then hold L for 5 cycles: one pulse only.
    bus.L = 1'b0;
    bus.R = 1'b0;
    tick();
    bus.L = 1'b1;
    #1;
    chk_pulses("lhold_c1", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk_pulses($sformatf("lhold_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_score("lhold", 3'd0, 3'd0, 2'b00);

    // Simultaneous edges cancel.
    bus.L = 1'b0;
    tick();
    bus.L = 1'b1;
    bus.R = 1'b1;
    #1;
    chk_pulses("tie", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_pulses("tie_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_score("tie_after", 3'd0, 3'd0, 2'b00);
    bus.L = 1'b0;
    bus.R = 1'b0;
    tick();

    // Plain move in mid chain.
    bus.R = 1'b1;
    #1;
    chk_pulses("rmove", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    bus.R = 1'b0;
    tick();

    // Left point: puck on the leftmost light, L edge.
    bus.lights = 9'b100000000;
    bus.L      = 1'b1;
    #1;
    chk_pulses("lpoint", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_score("lpoint_pre", 3'd0, 3'd0, 2'b00);
    tick();                                 // hold cycle 1
    bus.L = 1'b0;
    #1;
    chk_score("lpoint_post", 3'd1, 3'd0, 2'b10);
    chk_pulses("hold1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();                                 // hold cycle 2: R edge ignored
    bus.R = 1'b1;
    #1;
    chk_pulses("hold2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();                                 // hold cycle 3
    bus.R = 1'b0;
    #1;
    chk_pulses("hold3", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();                                 // hold cycle 4: win
    chk_pulses("hold4", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();                                 // back in PLAY
    chk_pulses("replay", 1'b0, 1'b0, 1'b0, 1'b0);

    // R edge with the puck on the opposite (left) end: forwarded, no point.
    bus.R = 1'b1;
    #1;
    chk_pulses("r_opp_end", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_pulses("r_opp_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_score("r_opp_after", 3'd1, 3'd0, 2'b10);
    bus.R = 1'b0;
    tick();

    // Right scores seven times to end the match.
    bus.lights = 9'b000000001;
    for (int k = 1; k <= 7; k++) begin
      bus.R = 1'b1;
      #1;
      chk($sformatf("rpt%0d.Rpress", k), 32'(bus.Rpress), 32'd0);
      tick();
      bus.R = 1'b0;
      #1;
      chk_score($sformatf("rpt%0d", k), 3'd1, 3'(k), 2'b01);
      tick();
      tick();
      chk($sformatf("rpt%0d.win_early", k), 32'(bus.win), 32'd0);
      tick();
      chk($sformatf("rpt%0d.win", k), 32'(bus.win), 32'd1);
      chk($sformatf("rpt%0d.go_in_hold", k), 32'(bus.gameOver), 32'd0);
      tick();
      chk($sformatf("rpt%0d.gameOver", k), 32'(bus.gameOver), (k == 7) ? 32'd1 : 32'd0);
    end

    // Match over: no pulses, scores frozen.
    bus.L      = 1'b1;
    bus.lights = 9'b100000000;
    #1;
    chk_pulses("done_l", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    bus.L = 1'b0;
    bus.R = 1'b1;
    #1;
    chk_pulses("done_r", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk_pulses("done_late", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_score("done_frozen", 3'd1, 3'd7, 2'b01);

    // Asynchronous reset out of DONE (mid-cycle).
    bus.R = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk_pulses("rst_done", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_score("rst_done", 3'd0, 3'd0, 2'b00);
    tick();
    Reset = 1'b0;
    tick();                                 // Lprev/Rprev now 0

    // Left point, then reset on the second HOLD cycle.
    bus.L = 1'b1;
    #1;
    chk("mid_pt.Lpress", 32'(bus.Lpress), 32'd0);
    tick();                                 // hold cycle 1
    bus.L = 1'b0;
    tick();                                 // hold cycle 2
    chk_score("mid_hold", 3'd1, 3'd0, 2'b10);
    #2;
    Reset = 1'b1;
    #1;
    chk_pulses("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_score("mid_rst", 3'd0, 3'd0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mid_rst_win%0d", i), 32'(bus.win), 32'd0);
    end
    Reset = 1'b0;
    tick();
    tick();
    chk_pulses("mid_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back in PLAY: a mid-chain R edge is forwarded.
    bus.lights = 9'b000010000;
    bus.R      = 1'b1;
    #1;
    chk_pulses("mid_play", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_score("final", 3'd0, 3'd0, 2'b00);
    bus.R = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
